// File: rtl/fm_sb_channel.sv
// fm_sb_channel: one spy-buffer channel. It captures a stream into a circular RAM, offers random readback, and replays the window.
// Optional: define FM_SB_DROP_CNT_EN to add the 16-bit drop_count output.
module fm_sb_channel #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int PB_MODE_WIDTH = 2
) (
    input  logic                     axi_clk,
    input  logic                     axi_rst,
    input  logic                     freeze,
    input  logic [PB_MODE_WIDTH-1:0] playback_mode,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_out_valid,
    output logic                     frozen,
    output logic                     pb_active,
    output logic                     pb_done,
    output logic [ADDR_WIDTH:0]      entry_count,
`ifdef FM_SB_DROP_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic [ADDR_WIDTH-1:0]    wr_ptr
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {S_REC, S_HOLD, S_PLAY, S_DONE} state_e;
    typedef enum logic [1:0] {PM_LIVE, PM_SINGLE, PM_LOOP} pm_e;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    state_e                state_q, state_d, start_state, idle_state;
    pm_e                   pm_eff;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, pb_ptr_q, pb_ptr_d, oldest, rb_addr;
    logic [CNT_W-1:0]      entry_count_q, entry_count_d, pb_left_q, pb_left_d;
    logic                  wr_en, pb_rd_en;
    logic                  pb_rd_vld_q, pb_rd_vld_d;
    logic [DATA_WIDTH-1:0] pb_ram_q, rd_ram_q;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_out_valid_q, data_out_valid_d;
    logic                  rd_valid_q, rd_valid_d, rd_hit_q, rd_hit_d;
    logic                  frozen_q, frozen_d, pb_active_q, pb_active_d, pb_done_q, pb_done_d;

    always_comb begin
        if (playback_mode == PB_MODE_WIDTH'(1))      pm_eff = PM_SINGLE;
        else if (playback_mode == PB_MODE_WIDTH'(2)) pm_eff = PM_LOOP;
        else                                         pm_eff = PM_LIVE;
    end

    // Once the buffer has wrapped, the oldest entry sits at the next write slot.
    assign oldest      = (entry_count_q == FULL) ? wr_ptr_q : '0;
    assign rb_addr     = oldest + rd_addr;
    assign start_state = (pm_eff == PM_SINGLE && entry_count_q == '0) ? S_DONE : S_PLAY;
    assign idle_state  = freeze ? S_HOLD : S_REC;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        entry_count_d    = entry_count_q;
        pb_ptr_d         = pb_ptr_q;
        pb_left_d        = pb_left_q;
        wr_en            = 1'b0;
        pb_rd_en         = 1'b0;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        unique case (state_q)
            S_REC: begin
                data_out_d       = data_in;
                data_out_valid_d = data_in_valid;
                if (pm_eff != PM_LIVE) state_d = start_state;
                else if (freeze)       state_d = S_HOLD;
                else if (data_in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    if (entry_count_q != FULL) entry_count_d = entry_count_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                data_out_d = data_in;
                if (pm_eff != PM_LIVE) state_d = start_state;
                else if (!freeze)      state_d = S_REC;
            end
            S_PLAY: begin
                if (pm_eff == PM_LIVE) begin
                    state_d = idle_state;
                end else begin
                    if (pb_rd_vld_q) data_out_d = pb_ram_q;
                    data_out_valid_d = pb_rd_vld_q;
                    if (pb_left_q != '0) begin
                        pb_rd_en  = 1'b1;
                        pb_ptr_d  = pb_ptr_q + ADDR_WIDTH'(1);
                        pb_left_d = pb_left_q - CNT_W'(1);
                        // The mode is sampled at the last read, so a loop reload never leaves a gap.
                        if (pb_left_q == CNT_W'(1) && pm_eff == PM_LOOP) begin
                            pb_ptr_d  = oldest;
                            pb_left_d = entry_count_q;
                        end
                    end else if (pm_eff == PM_LOOP) begin
                        pb_ptr_d  = oldest;
                        pb_left_d = entry_count_q;
                    end else if (!pb_rd_vld_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (pm_eff == PM_LIVE) state_d = idle_state;
            end
            default: state_d = S_REC;
        endcase
        if (state_d == S_PLAY && state_q != S_PLAY) begin
            pb_ptr_d  = oldest;
            pb_left_d = entry_count_q;
        end
        pb_rd_vld_d = pb_rd_en;
        rd_valid_d  = rd_en;
        rd_hit_d    = rd_en && ({1'b0, rd_addr} < entry_count_q);
        frozen_d    = (state_d != S_REC);
        pb_active_d = (state_d == S_PLAY);
        pb_done_d   = (state_d == S_DONE);
    end

    // NOTE: the RAM and its read registers carry no reset, so they map onto block RAM.
    always_ff @(posedge axi_clk) begin
        if (wr_en)    mem[wr_ptr_q] <= data_in;
        if (pb_rd_en) pb_ram_q      <= mem[pb_ptr_q];
        if (rd_en)    rd_ram_q      <= mem[rb_addr];
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge values.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q          <= S_REC;
            wr_ptr_q         <= '0;
            entry_count_q    <= '0;
            pb_ptr_q         <= '0;
            pb_left_q        <= '0;
            pb_rd_vld_q      <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_hit_q         <= 1'b0;
            frozen_q         <= 1'b0;
            pb_active_q      <= 1'b0;
            pb_done_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            entry_count_q    <= entry_count_d;
            pb_ptr_q         <= pb_ptr_d;
            pb_left_q        <= pb_left_d;
            pb_rd_vld_q      <= pb_rd_vld_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            rd_valid_q       <= rd_valid_d;
            rd_hit_q         <= rd_hit_d;
            frozen_q         <= frozen_d;
            pb_active_q      <= pb_active_d;
            pb_done_q        <= pb_done_d;
        end
    end

`ifdef FM_SB_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (state_d == S_REC && state_q != S_REC)
            drop_count_d = '0;
        else if (data_in_valid && !wr_en && drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 16'd1;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) drop_count_q <= '0;
        else         drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`endif

    assign rd_data        = rd_hit_q ? rd_ram_q : '0;
    assign rd_valid       = rd_valid_q;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frozen         = frozen_q;
    assign pb_active      = pb_active_q;
    assign pb_done        = pb_done_q;
    assign entry_count    = entry_count_q;
    assign wr_ptr         = wr_ptr_q;

endmodule

// File: tb/tb_fm_sb_channel.sv
// Self-checking bench for fm_sb_channel (depth 8). A queue of written words models the capture window.
// Define FM_SB_DROP_CNT_EN to also check drop_count.
module tb_fm_sb_channel;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          axi_clk, axi_rst, freeze, data_in_valid, rd_en;
    logic [1:0]    playback_mode;
    logic [DW-1:0] data_in, rd_data, data_out;
    logic [AW-1:0] rd_addr, wr_ptr;
    logic [AW:0]   entry_count;
    logic          rd_valid, data_out_valid, frozen, pb_active, pb_done;
`ifdef FM_SB_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] hist [$];
    int unsigned   total_wr;

    fm_sb_channel #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PB_MODE_WIDTH(2)) dut (
        .axi_clk        (axi_clk),
        .axi_rst        (axi_rst),
        .freeze         (freeze),
        .playback_mode  (playback_mode),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frozen         (frozen),
        .pb_active      (pb_active),
        .pb_done        (pb_done),
        .entry_count    (entry_count),
`ifdef FM_SB_DROP_CNT_EN
        .drop_count     (drop_count),
`endif
        .wr_ptr         (wr_ptr)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    function automatic void model_reset();
        hist.delete();
        total_wr = 0;
    endfunction

    function automatic void model_push(input logic [DW-1:0] w);
        hist.push_back(w);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        total_wr++;
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        return (a < hist.size()) ? hist[a] : '0;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_dvalid"}, 64'(data_out_valid), 64'(0));
        check({tag, "_dout"},   64'(data_out),       64'(0));
        check({tag, "_frozen"}, 64'(frozen),         64'(0));
        check({tag, "_pbact"},  64'(pb_active),      64'(0));
        check({tag, "_pbdone"}, 64'(pb_done),        64'(0));
        check({tag, "_count"},  64'(entry_count),    64'(0));
        check({tag, "_wrptr"},  64'(wr_ptr),         64'(0));
        check({tag, "_rvalid"}, 64'(rd_valid),       64'(0));
        check({tag, "_rdata"},  64'(rd_data),        64'(0));
`ifdef FM_SB_DROP_CNT_EN
        check({tag, "_drop"},   64'(drop_count),     64'(0));
`endif
    endtask

    task automatic do_reset();
        axi_rst = 1'b1;
        step();
        axi_rst = 1'b0;
        model_reset();
    endtask

    // Writes one word in REC and checks the live echo one cycle later.
    task automatic write_word(input logic [DW-1:0] w);
        data_in       = w;
        data_in_valid = 1'b1;
        step();
        model_push(w);
        check("live_valid", 64'(data_out_valid), 64'(1));
        check("live_data",  64'(data_out),       64'(w));
        data_in_valid = 1'b0;
    endtask

    task automatic readback(input string tag, input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        step();
        check({tag, "_rvalid"}, 64'(rd_valid), 64'(1));
        check({tag, "_rdata"},  64'(rd_data),  64'(model_read(a)));
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;
        logic          v, re;
        int            ra;

        axi_rst = 1'b1; freeze = 1'b0; playback_mode = 2'd0;
        data_in = '0; data_in_valid = 1'b0; rd_en = 1'b0; rd_addr = '0;
        model_reset();
        step();
        step();
        check_reset_state("reset");
        axi_rst = 1'b0;

        // Capture 1..5, freeze, read back the window and one address past it.
        for (int i = 1; i <= 5; i++) write_word(DW'(i));
        freeze = 1'b1;
        step();
        check("t1_frozen", 64'(frozen),      64'(1));
        check("t1_count",  64'(entry_count), 64'(hist.size()));
        check("t1_wrptr",  64'(wr_ptr),      64'(total_wr % DEPTH));
        for (int a = 0; a <= 5; a++) readback("t1_rb", a);
        step();
        check("t1_rvalid_idle", 64'(rd_valid), 64'(0));

        for (int i = 0; i < 7; i++) begin
            data_in       = $urandom;
            data_in_valid = 1'b1;
            step();
            check("hold_no_out", 64'(data_out_valid), 64'(0));
        end
        data_in_valid = 1'b0;
        step();
        check("hold_count_kept", 64'(entry_count), 64'(hist.size()));
`ifdef FM_SB_DROP_CNT_EN
        check("drop_seven", 64'(drop_count), 64'(7));
`endif
        freeze = 1'b0;
        step();
        check("unfreeze_frozen", 64'(frozen), 64'(0));
`ifdef FM_SB_DROP_CNT_EN
        check("drop_cleared", 64'(drop_count), 64'(0));
`endif

        // Wrap: ten words into an 8-deep buffer.
        do_reset();
        check("t2_count0", 64'(entry_count), 64'(0));
        for (int i = 0; i < 10; i++) write_word(DW'(32'hA0 + i));
        freeze = 1'b1;
        step();
        check("t2_count",  64'(entry_count), 64'(8));
        check("t2_wrptr",  64'(wr_ptr),      64'(2));
        check("t2_model",  64'(model_read(0)), 64'(32'hA2));
        readback("t2_rb0", 0);
        for (int i = 0; i < 6; i++) readback("t2_rbrand", int'($urandom_range(0, DEPTH - 1)));
        freeze = 1'b0;
        step();

        // Random recording; reserved mode 3 must behave as live.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            w = $urandom;
            v = 1'($urandom_range(0, 1));
            data_in       = w;
            data_in_valid = v;
            playback_mode = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
            step();
            if (v) model_push(w);
            check("rand_live_valid", 64'(data_out_valid), 64'(v));
            if (v) check("rand_live_data", 64'(data_out), 64'(w));
        end
        playback_mode = 2'd0;
        data_in_valid = 1'b0;
        step();
        check("rand_count", 64'(entry_count), 64'(hist.size()));
        check("rand_wrptr", 64'(wr_ptr),      64'(total_wr % DEPTH));
        freeze = 1'b1;
        step();
        for (int a = 0; a < DEPTH; a++) readback("rand_rb", a);
        freeze = 1'b0;
        step();

        // Single-pass playback of three words.
        do_reset();
        for (int i = 1; i <= 3; i++) write_word(DW'(i));
        playback_mode = 2'd1;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) check("single_pbact", 64'(pb_active), 64'(1));
            check("single_valid", 64'(data_out_valid), 64'(k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) check("single_data", 64'(data_out), 64'(hist[k - 2]));
        end
        check("single_done",   64'(pb_done),   64'(1));
        check("single_pbact0", 64'(pb_active), 64'(0));
        check("single_frozen", 64'(frozen),    64'(1));
        playback_mode = 2'd0;
        step();
        check("done_exit_pbdone", 64'(pb_done), 64'(0));
        check("done_exit_frozen", 64'(frozen),  64'(0));

        // Loop playback with concurrent readbacks, then abort back to REC.
        playback_mode = 2'd2;
        step();
        for (int k = 1; k <= 10; k++) begin
            re      = 1'($urandom_range(0, 1));
            ra      = int'($urandom_range(0, DEPTH - 1));
            rd_en   = re;
            rd_addr = AW'(ra);
            step();
            check("loop_valid", 64'(data_out_valid), 64'(k >= 2));
            if (k >= 2) check("loop_data", 64'(data_out), 64'(hist[(k - 2) % hist.size()]));
            if (re) check("loop_rb_data", 64'(rd_data), 64'(model_read(ra)));
            check("loop_rb_valid", 64'(rd_valid), 64'(re));
        end
        rd_en         = 1'b0;
        playback_mode = 2'd0;
        step();
        check("abort_suppressed", 64'(data_out_valid), 64'(0));
        write_word($urandom);
        check("abort_rec_frozen", 64'(frozen),      64'(0));
        check("abort_rec_pbact",  64'(pb_active),   64'(0));
        check("abort_rec_count",  64'(entry_count), 64'(hist.size()));

        // Empty window: single-pass goes straight to DONE, loop idles in PLAY.
        do_reset();
        playback_mode = 2'd1;
        step();
        check("empty_done",   64'(pb_done),        64'(1));
        check("empty_pbact",  64'(pb_active),      64'(0));
        check("empty_valid",  64'(data_out_valid), 64'(0));
        playback_mode = 2'd0;
        step();
        playback_mode = 2'd2;
        for (int k = 0; k < 4; k++) begin
            step();
            check("empty_loop_valid", 64'(data_out_valid), 64'(0));
            check("empty_loop_pbact", 64'(pb_active),      64'(1));
        end
        playback_mode = 2'd0;
        step();

        // Reset in the middle of loop playback.
        do_reset();
        for (int i = 0; i < 4; i++) write_word($urandom);
        playback_mode = 2'd2;
        step();
        step();
        step();
        check("pre_rst_pbact", 64'(pb_active), 64'(1));
        axi_rst = 1'b1;
        step();
        check_reset_state("midplay_rst");
        axi_rst       = 1'b0;
        playback_mode = 2'd0;
        model_reset();
        step();
        check("post_rst_count", 64'(entry_count), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
